imem_loader: RTL and testbench

Writer side of the instruction memory port. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them to consecutive instruction memory addresses starting at 0. While a load is in progress it holds the CPU in reset, so instruction fetch only starts once the program image is fully written. It drives the BRAM write port (`en`/`we`/`addr`/`din`) that the fetch path reads through.

---
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory port.
// It receives a byte stream (LEN_HI, LEN_LO, then 4*N data bytes) and
// assembles big-endian 32-bit words. Each word is written to consecutive
// word addresses starting at 0. The CPU is held in reset while a load
// is in progress.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined,
// a trailing XOR checksum byte follows the data bytes.
//
// state  | meaning
// IDLE   | no session since reset
// LEN_HI | waiting for the word-count high byte
// LEN_LO | waiting for the word-count low byte
// DATA   | collecting the four bytes of a word
// WRITE  | one-cycle memory write of the assembled word
// CHK    | waiting for the checksum byte (checksum build only)
// DONE   | session completed; terminal until the next start
// ERR    | session aborted; terminal until the next start
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // Where a session goes once all words are written (or N = 0).
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W:0]   ww_q, ww_d;
  logic              accept;
  logic [16:0]       len_lo_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  assign accept   = in_valid && in_ready;
  assign len_lo_n = {1'b0, len_q[15:8], in_byte};

  // Next-state logic: length capture, byte assembly, write sequencing.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lane_d  = lane_q;
    data_d  = data_q;
    ww_d    = ww_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          ww_d    = '0;
          lane_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d   = 8'h00;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {in_byte, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = len_lo_n[15:0];
          if (len_lo_n == 17'd0) begin
            state_d = S_FINISH;
          end else if (len_lo_n > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          data_d = {data_q[23:0], in_byte};
          lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d  = chk_q ^ in_byte;
`endif
          if (lane_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        ww_d = ww_q + 1'b1;
        if ((17'(ww_q) + 17'd1) < {1'b0, len_q}) begin
          state_d = S_DATA;
        end else begin
          state_d = S_FINISH;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (in_byte == chk_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      ww_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      ww_q    <= ww_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  // Outputs decoded from the current state; mem_din is the assembled word.
  always_comb begin
    in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
               (state_q == S_CHK) ||
`endif
               (state_q == S_DATA);
    mem_we        = (state_q == S_WRITE);
    mem_en        = mem_we;
    mem_addr      = ww_q[ADDR_W-1:0];
    mem_din       = data_q;
    busy          = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    cpu_hold      = busy;
    done          = (state_q == S_DONE);
    load_err      = (state_q == S_ERR);
    words_written = ww_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader.
// A write monitor logs every memory write. Each scenario task builds the
// expected program image and compares the log against it.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_byte = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready, mem_en, mem_we, cpu_hold, busy, done, load_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [ADDR_W:0]   words_written;

  int checks = 0;
  int failures = 0;
  int timeouts = 0;
  int bad_ready = 0;
  int bad_en = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  logic [31:0]       exp_words[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .load_err(load_err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Write monitor: logs writes, flags in_ready during WRITE, checks mem_en == mem_we.
  always @(negedge clk) begin
    if (mem_en !== mem_we) bad_en++;
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_din);
      if (in_ready !== 1'b0) bad_ready++;
    end
  end

  // Reference model: word i of the image must land at address i, once.
  function automatic int log_errs();
    int e = 0;
    if (wr_addr.size() != exp_words.size()) e++;
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (i >= exp_words.size()) e++;
      else if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_words[i]) e++;
    end
    return e;
  endfunction

  function automatic logic [7:0] model_xor();
    logic [7:0] x = 8'h00;
    foreach (exp_words[i]) x = x ^ exp_words[i][31:24] ^ exp_words[i][23:16]
                                 ^ exp_words[i][15:8] ^ exp_words[i][7:0];
    return x;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    sync();
    start = 1'b0;
  endtask

  // Entered and left just after a rising edge; returns in the cycle after the accept.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gaps;
    int budget;
    logic acc;
    gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    in_valid = 1'b0;
    repeat (gaps) sync();
    in_byte  = b;
    in_valid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      sync();
      if (acc) break;
      budget++;
      if (budget > 50) begin
        timeouts++;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] n, input int gap, input logic corrupt);
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    foreach (exp_words[i]) begin
      send_byte(exp_words[i][31:24], gap);
      send_byte(exp_words[i][23:16], gap);
      send_byte(exp_words[i][15:8], gap);
      send_byte(exp_words[i][7:0], gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(corrupt ? (model_xor() ^ 8'h01) : model_xor(), gap);
`else
    if (corrupt) timeouts = timeouts + 0;
`endif
  endtask

  task automatic wait_end();
    int budget = 0;
    while (!(done === 1'b1 || load_err === 1'b1)) begin
      sync();
      budget++;
      if (budget > 50) begin
        timeouts++;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) sync();
    @(negedge clk);
    checks++;
    if ({in_ready, mem_en, mem_we, cpu_hold, busy, done, load_err} !== 7'b0) begin
      failures++; $display("FAIL reset_flags_in_reset got=%b exp=0", {in_ready, mem_en, mem_we, cpu_hold, busy, done, load_err});
    end
    sync();
    rst = 1'b1;
    sync();
    @(negedge clk);
    checks++;
    if ({in_ready, mem_en, mem_we, cpu_hold, busy, done, load_err} !== 7'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0", {in_ready, mem_en, mem_we, cpu_hold, busy, done, load_err});
    end
    checks++;
    if (mem_addr !== '0 || mem_din !== 32'h0) begin
      failures++; $display("FAIL reset_mem got addr=%h din=%h exp=0", mem_addr, mem_din);
    end
    checks++;
    if (words_written !== '0) begin
      failures++; $display("FAIL reset_words got=%0d exp=0", words_written);
    end
    sync();
  endtask

  task automatic test_basic();
    exp_words = '{32'hDEADBEEF, 32'h12345678};
    clear_log();
    pulse_start();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL basic_start_latency got ready=%b hold=%b exp=1 1", in_ready, cpu_hold);
    end
    sync();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    foreach (exp_words[i]) begin
      send_byte(exp_words[i][31:24], 0); send_byte(exp_words[i][23:16], 0);
      send_byte(exp_words[i][15:8], 0);  send_byte(exp_words[i][7:0], 0);
    end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL basic_write_cycle got we=%b ready=%b exp=1 0", mem_we, in_ready);
    end
    checks++;
    if (mem_addr !== 10'd1 || mem_din !== 32'h12345678) begin
      failures++; $display("FAIL basic_write_data got addr=%h din=%h exp=001 12345678", mem_addr, mem_din);
    end
    sync();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(model_xor(), 0);
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || words_written !== 11'd2) begin
      failures++; $display("FAIL basic_done got done=%b hold=%b words=%0d exp=1 0 2", done, cpu_hold, words_written);
    end
    checks++;
    if (log_errs() !== 0) begin
      failures++; $display("FAIL basic_image got errs=%0d writes=%0d exp errs=0 writes=2", log_errs(), wr_addr.size());
    end
    sync();
  endtask

  task automatic test_zero_len();
    exp_words.delete();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || words_written !== 11'd0) begin
      failures++; $display("FAIL zero_len_done got done=%b hold=%b words=%0d exp=1 0 0", done, cpu_hold, words_written);
    end
    sync();
    checks++;
    if (wr_addr.size() !== 0) begin
      failures++; $display("FAIL zero_len_writes got=%0d exp=0", wr_addr.size());
    end
  endtask

  task automatic test_too_long();
    exp_words.delete();
    clear_log();
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL too_long got err=%b hold=%b done=%b ready=%b exp=1 0 0 0", load_err, cpu_hold, done, in_ready);
    end
    repeat (3) sync();
    checks++;
    if (wr_addr.size() !== 0 || load_err !== 1'b1) begin
      failures++; $display("FAIL too_long_sticky got writes=%0d err=%b exp=0 1", wr_addr.size(), load_err);
    end
  endtask

  task automatic test_full_random_gaps();
    exp_words.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) exp_words.push_back(32'(i));
    clear_log();
    bad_ready = 0;
    pulse_start();
    send_frame(16'(1 << ADDR_W), 2, 1'b0);
    wait_end();
    checks++;
    if (done !== 1'b1 || words_written !== 11'd1024) begin
      failures++; $display("FAIL full_done got done=%b words=%0d exp=1 1024", done, words_written);
    end
    checks++;
    if (log_errs() !== 0) begin
      failures++; $display("FAIL full_image got errs=%0d writes=%0d exp errs=0 writes=1024", log_errs(), wr_addr.size());
    end
    checks++;
    if (bad_ready !== 0) begin
      failures++; $display("FAIL full_ready_on_write got=%0d exp=0", bad_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(8, 1);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      clear_log();
      pulse_start();
      send_frame(16'(n), $urandom_range(3, 0), 1'b0);
      wait_end();
      sync();
      checks++;
      if (done !== 1'b1 || words_written !== 11'(n) || log_errs() !== 0) begin
        failures++; $display("FAIL back_to_back_%0d got done=%b words=%0d errs=%0d exp=1 %0d 0", k, done, words_written, log_errs(), n);
      end
    end
  endtask

  task automatic test_start_while_busy();
    exp_words = '{32'hCAFE0001};
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hCA, 0); send_byte(8'hFE, 0);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(model_xor(), 0);
`endif
    wait_end();
    sync();
    checks++;
    if (done !== 1'b1 || words_written !== 11'd1 || log_errs() !== 0) begin
      failures++; $display("FAIL start_while_busy got done=%b words=%0d errs=%0d exp=1 1 0", done, words_written, log_errs());
    end
  endtask

  task automatic test_reset_mid();
    exp_words = '{$urandom, $urandom};
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(exp_words[0][31:24], 0); send_byte(exp_words[0][23:16], 0);
    send_byte(exp_words[0][15:8], 0);  send_byte(exp_words[0][7:0], 0);
    send_byte(exp_words[1][31:24], 0); send_byte(exp_words[1][23:16], 0);
    rst = 1'b0;
    sync();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, mem_en, mem_we, cpu_hold, busy, done, load_err} !== 7'b0 ||
        mem_addr !== '0 || mem_din !== 32'h0 || words_written !== '0) begin
      failures++; $display("FAIL reset_mid_outputs got flags=%b addr=%h din=%h words=%0d exp=0",
                           {in_ready, mem_en, mem_we, cpu_hold, busy, done, load_err}, mem_addr, mem_din, words_written);
    end
    checks++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== '0 || wr_data[0] !== exp_words[0]) begin
      failures++; $display("FAIL reset_mid_partial got writes=%0d exp=1", wr_addr.size());
    end
    sync();
    exp_words = '{$urandom, $urandom};
    clear_log();
    pulse_start();
    send_frame(16'd2, 1, 1'b0);
    wait_end();
    sync();
    checks++;
    if (done !== 1'b1 || log_errs() !== 0) begin
      failures++; $display("FAIL reset_mid_reload got done=%b errs=%0d exp=1 0", done, log_errs());
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    exp_words = '{32'h11223344};
    clear_log();
    pulse_start();
    send_frame(16'd1, 0, 1'b0);
    wait_end();
    checks++;
    if (done !== 1'b1 || load_err !== 1'b0) begin
      failures++; $display("FAIL checksum_good got done=%b err=%b exp=1 0", done, load_err);
    end
    clear_log();
    pulse_start();
    send_frame(16'd1, 0, 1'b1);
    wait_end();
    sync();
    checks++;
    if (done !== 1'b0 || load_err !== 1'b1 || log_errs() !== 0) begin
      failures++; $display("FAIL checksum_bad got done=%b err=%b errs=%0d exp=0 1 0", done, load_err, log_errs());
    end
  endtask
`endif

  task automatic test_health();
    checks++;
    if (timeouts !== 0) begin
      failures++; $display("FAIL handshake_timeouts got=%0d exp=0", timeouts);
    end
    checks++;
    if (bad_en !== 0) begin
      failures++; $display("FAIL en_equals_we got=%0d exp=0", bad_en);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_too_long();
    test_full_random_gaps();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_health();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
